// File: rtl/fp16_align_shift_if.sv
// Operand/result handshake bundle for the FP16 exponent-alignment stage.
// The master drives operands and out_ready; the slave (the aligner) drives results.
interface fp16_align_shift_if #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10
);
  localparam int unsigned W      = 1 + EXP_W + MANT_W;
  localparam int unsigned FRAC_W = MANT_W + 3;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] big_frac;
  logic [FRAC_W-1:0] small_frac;
  logic              big_sign;
  logic              small_sign;
  logic              eff_sub;
  logic              special;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, exp_out, big_frac, small_frac,
           big_sign, small_sign, eff_sub, special
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, exp_out, big_frac, small_frac,
           big_sign, small_sign, eff_sub, special
  );
endinterface

// File: rtl/fp16_align_shift.sv
// Pre-add exponent alignment: orders two FP16 operands by magnitude, then right-shifts
// the smaller fraction by the exponent difference with a sticky bit. Two-stage pipeline.
module fp16_align_shift #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10
) (
  input logic               CLK,
  input logic               nRST,
  fp16_align_shift_if.slave bus
);
  localparam int unsigned W      = 1 + EXP_W + MANT_W;
  localparam int unsigned FRAC_W = MANT_W + 3;
  localparam logic [EXP_W-1:0] ShMax = EXP_W'(FRAC_W);

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1 combinational unpack and magnitude ordering
  logic              b_big;
  logic [W-1:0]      big_op, small_op;
  logic [EXP_W-1:0]  big_raw, small_raw, big_eff, small_eff;
  logic [FRAC_W-1:0] big13, small13;
  logic              special_in;

  always_comb begin
    b_big      = bus.b[W-2:0] > bus.a[W-2:0];
    big_op     = b_big ? bus.b : bus.a;
    small_op   = b_big ? bus.a : bus.b;
    big_raw    = big_op[W-2:MANT_W];
    small_raw  = small_op[W-2:MANT_W];
    // Subnormals share the exponent of the smallest normal.
    big_eff    = (big_raw == '0) ? EXP_W'(1) : big_raw;
    small_eff  = (small_raw == '0) ? EXP_W'(1) : small_raw;
    big13      = {big_raw != '0, big_op[MANT_W-1:0], 2'b00};
    small13    = {small_raw != '0, small_op[MANT_W-1:0], 2'b00};
    special_in = (&bus.a[W-2:MANT_W]) | (&bus.b[W-2:MANT_W]);
  end

  logic [EXP_W-1:0]  s1_exp_q, s1_diff_q;
  logic [FRAC_W-1:0] s1_big_q, s1_small_q;
  logic              s1_big_sign_q, s1_small_sign_q, s1_eff_sub_q, s1_special_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q      <= 1'b0;
      s1_exp_q        <= '0;
      s1_diff_q       <= '0;
      s1_big_q        <= '0;
      s1_small_q      <= '0;
      s1_big_sign_q   <= 1'b0;
      s1_small_sign_q <= 1'b0;
      s1_eff_sub_q    <= 1'b0;
      s1_special_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_exp_q        <= big_eff;
        s1_diff_q       <= big_eff - small_eff;
        s1_big_q        <= big13;
        s1_small_q      <= small13;
        s1_big_sign_q   <= big_op[W-1];
        s1_small_sign_q <= small_op[W-1];
        s1_eff_sub_q    <= bus.a[W-1] ^ bus.b[W-1];
        s1_special_q    <= special_in;
      end
    end
  end

  // Stage 2 combinational shift; low half of the wide vector holds the shifted-out bits.
  logic [EXP_W-1:0]    sh;
  logic [2*FRAC_W-1:0] wide;
  logic [FRAC_W-1:0]   aligned;

  always_comb begin
    sh      = (s1_diff_q >= ShMax) ? ShMax : s1_diff_q;
    wide    = {s1_small_q, {FRAC_W{1'b0}}} >> sh;
    aligned = {wide[2*FRAC_W-1:FRAC_W+1], wide[FRAC_W] | (|wide[FRAC_W-1:0])};
  end

  logic [EXP_W-1:0]  s2_exp_q;
  logic [FRAC_W-1:0] s2_big_q, s2_small_q;
  logic              s2_big_sign_q, s2_small_sign_q, s2_eff_sub_q, s2_special_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid_q      <= 1'b0;
      s2_exp_q        <= '0;
      s2_big_q        <= '0;
      s2_small_q      <= '0;
      s2_big_sign_q   <= 1'b0;
      s2_small_sign_q <= 1'b0;
      s2_eff_sub_q    <= 1'b0;
      s2_special_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_exp_q        <= s1_exp_q;
        s2_big_q        <= s1_big_q;
        s2_small_q      <= aligned;
        s2_big_sign_q   <= s1_big_sign_q;
        s2_small_sign_q <= s1_small_sign_q;
        s2_eff_sub_q    <= s1_eff_sub_q;
        s2_special_q    <= s1_special_q;
      end
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.exp_out    = s2_exp_q;
  assign bus.big_frac   = s2_big_q;
  assign bus.small_frac = s2_small_q;
  assign bus.big_sign   = s2_big_sign_q;
  assign bus.small_sign = s2_small_sign_q;
  assign bus.eff_sub    = s2_eff_sub_q;
  assign bus.special    = s2_special_q;
endmodule
